a2d_serf: RTL and testbench

//  SPI serf emulating the 8-channel 12-bit ADC, the responder end of the A2D
//  SPI link. Decodes 16-bit command frames from the SPI monarch and returns
//  the addressed channel's sample in the following frame.

---
 rtl/a2d_serf.sv | 145 ++++++++++++++
 tb/tb_a2d_serf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_serf.sv
// SPI serf standing in for the 8-channel A2D converter: decodes 16-bit command
// frames and returns the addressed channel's sample in the following frame.
//
// state | meaning
// IDLE  | SS_n high, MISO parked at 1, waiting for ss_fall
// ARMED | frame started, response loaded, waiting for first sclk_rise
// SHIFT | shifting: sample MOSI on sclk_rise, advance shft on sclk_fall
module a2d_serf #(
  parameter int         DATA_W   = 12,
  parameter logic [2:0] RST_CHNL = 3'd0,
  parameter int         SYNC_STG = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic [15:0]           cmd,
  output logic [2:0]            chnl,
  output logic                  frm_done,
  output logic                  frm_err
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STG-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                ss_s, sclk_s, mosi_s, ss_d, sclk_d;
  logic                ss_fall, ss_rise, sclk_fall, sclk_rise;

  logic [15:0] shft, shft_nxt, cmd_nxt, frame_word, sample_word;
  logic [4:0]  rise_cnt, cnt_nxt;
  logic        mosi_smp, smp_nxt;
  logic [2:0]  chnl_nxt;
  logic        done_nxt, err_nxt;

  // Sync and edge-detect flops reset high so a released reset with idle
  // pins never looks like a select or clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '1;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STG-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], MOSI};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  assign ss_s   = ss_sync[SYNC_STG-1];
  assign sclk_s = sclk_sync[SYNC_STG-1];
  assign mosi_s = mosi_sync[SYNC_STG-1];

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  assign sample_word = {{(16-DATA_W){1'b0}}, ch_data[chnl*DATA_W +: DATA_W]};
  assign frame_word  = {shft[14:0], mosi_smp};
  assign MISO        = (state == IDLE) ? 1'b1 : shft[15];

  always_comb begin
    state_nxt = state;
    shft_nxt  = shft;
    cnt_nxt   = rise_cnt;
    smp_nxt   = mosi_smp;
    cmd_nxt   = cmd;
    chnl_nxt  = chnl;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = ARMED;
          shft_nxt  = sample_word;
          cnt_nxt   = 5'd0;
        end
      end
      ARMED: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (sclk_rise) begin
          smp_nxt   = mosi_s;
          cnt_nxt   = rise_cnt + 5'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // ss_rise takes priority over any sclk edge in the same cycle
        if (ss_rise) begin
          state_nxt = IDLE;
          if (rise_cnt == 5'd16) begin
            cmd_nxt  = frame_word;
            chnl_nxt = frame_word[13:11];
            done_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          if (sclk_fall)
            shft_nxt = frame_word;
          if (sclk_rise) begin
            smp_nxt = mosi_s;
            if (rise_cnt != 5'd31)
              cnt_nxt = rise_cnt + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shft     <= '0;
      rise_cnt <= '0;
      mosi_smp <= 1'b0;
      cmd      <= '0;
      chnl     <= RST_CHNL;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shft     <= shft_nxt;
      rise_cnt <= cnt_nxt;
      mosi_smp <= smp_nxt;
      cmd      <= cmd_nxt;
      chnl     <= chnl_nxt;
      frm_done <= done_nxt;
      frm_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_a2d_serf.sv
// Directed bench for a2d_serf: a monarch task drives SPI frames while a
// frame-level model (channel table, last command) predicts every response.
module tb_a2d_serf;

  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         SS_n, SCLK, MOSI;
  logic         MISO;
  logic [95:0]  ch_data;
  logic [15:0]  cmd;
  logic [2:0]   chnl;
  logic         frm_done, frm_err;

  a2d_serf dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_data(ch_data), .cmd(cmd), .chnl(chnl), .frm_done(frm_done), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [11:0] m_ch [8];
  logic [15:0] m_cmd;
  logic [2:0]  m_chnl;
  int          exp_done = 0, exp_err = 0;
  int          done_seen = 0, err_seen = 0;
  logic        idle_chk = 1'b0;
  logic [15:0] rx;
  logic [11:0] rr_lit [4];
  logic [2:0]  rr_ch [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_data[k*12 +: 12] = v;
    m_ch[k] = v;
  endtask

  // Cycle-by-cycle compare against the model whenever the link is idle,
  // plus checks on every completion pulse.
  always @(negedge clk) begin
    if (frm_done) begin
      done_seen++;
      check("done_cmd", {16'h0, cmd}, {16'h0, m_cmd});
      check("done_chnl", {29'h0, chnl}, {29'h0, m_chnl});
    end
    if (frm_err) err_seen++;
    if (idle_chk)
      check("idle_state", {11'h0, MISO, cmd, chnl, frm_done, frm_err},
            {11'h0, 1'b1, m_cmd, m_chnl, 1'b0, 1'b0});
  end

  task automatic do_reset();
    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b1;
    m_cmd  = 16'h0;
    m_chnl = 3'd0;
    wait_clk(2);
    idle_chk = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic spi_frame(input logic [15:0] tx, input int nbits, input int rst_at,
                           input int chg_at, input logic [11:0] chg_val,
                           output logic [15:0] rx_o);
    logic [15:0] exp_rsp;
    logic [15:0] r;
    int          ed, ee;
    exp_rsp  = {4'h0, m_ch[m_chnl]};
    ed       = exp_done;
    ee       = exp_err;
    r        = 16'h0;
    idle_chk = 1'b0;
    SS_n = 1'b0;
    wait_clk(HALF);
    SCLK = 1'b0;
    MOSI = tx[15];
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        do_reset();
        rx_o = r;
        return;
      end
      if (i == chg_at) begin
        ch_data[m_chnl*12 +: 12] = chg_val;
        m_ch[m_chnl] = chg_val;
      end
      r = {r[14:0], MISO};
      SCLK = 1'b1;
      wait_clk(HALF);
      if (i < nbits - 1) begin
        SCLK = 1'b0;
        MOSI = tx[14-i];
        wait_clk(HALF);
      end
    end
    SS_n = 1'b1;
    SCLK = 1'b1;
    if (nbits == 16) begin
      m_cmd  = tx;
      m_chnl = tx[13:11];
      exp_done = ed + 1;
    end else begin
      exp_err = ee + 1;
    end
    wait_clk(HALF);
    if (nbits > 0)
      check("frame_rx", {16'h0, r}, {16'h0, exp_rsp >> (16 - nbits)});
    check("done_count", done_seen, exp_done);
    check("err_count", err_seen, exp_err);
    idle_chk = 1'b1;
    rx_o = r;
  endtask

  task automatic frame(input logic [15:0] tx, output logic [15:0] rx_o);
    spi_frame(tx, 16, -1, -1, 12'h0, rx_o);
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b1;
    ch_data = '0;
    set_ch(0, 12'hABC); set_ch(1, 12'h101); set_ch(2, 12'h202); set_ch(3, 12'h303);
    set_ch(4, 12'h444); set_ch(5, 12'h555); set_ch(6, 12'h666); set_ch(7, 12'h777);
    m_cmd = 16'h0; m_chnl = 3'd0;
    wait_clk(4);
    check("rst_outputs", {11'h0, MISO, cmd, chnl, frm_done, frm_err},
          {11'h0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0});
    rst = 1'b0;
    wait_clk(4);
    idle_chk = 1'b1;

    // 1: first frame after reset returns channel 0
    frame(16'h0000, rx);
    check("t1_rx", {16'h0, rx}, 32'h0ABC);
    check("t1_done", done_seen, 1);

    // 2: command ch4, then dummy read
    frame(16'h2000, rx);
    check("t2_chnl", {29'h0, chnl}, 32'd4);
    frame(16'h0000, rx);
    check("t2_rx", {16'h0, rx}, 32'h0444);

    // 3: round robin
    set_ch(0, 12'h111);
    rr_ch[0] = 3'd0; rr_ch[1] = 3'd4; rr_ch[2] = 3'd5; rr_ch[3] = 3'd6;
    rr_lit[0] = 12'h111; rr_lit[1] = 12'h444; rr_lit[2] = 12'h555; rr_lit[3] = 12'h666;
    for (int k = 0; k < 4; k++) begin
      frame({2'b00, rr_ch[k], 11'h0}, rx);
      frame(16'h0000, rx);
      check("t3_rx", {16'h0, rx}, {20'h0, rr_lit[k]});
    end

    // 4: short frame flags an error and leaves cmd/chnl alone
    spi_frame(16'h3800, 9, -1, -1, 12'h0, rx);
    check("t4_err", err_seen, 1);
    check("t4_chnl", {29'h0, chnl}, 32'd0);
    frame(16'h1800, rx);
    check("t4_rx_after", {16'h0, rx}, 32'h0111);
    check("t4_chnl3", {29'h0, chnl}, 32'd3);
    frame(16'h0000, rx);
    check("t4_rx_ch3", {16'h0, rx}, 32'h0303);

    // zero-bit frame
    spi_frame(16'h0000, 0, -1, -1, 12'h0, rx);
    check("zero_bit_err", err_seen, 2);

    // 5: sample change mid-frame does not affect the frame in flight
    set_ch(2, 12'h123);
    frame(16'h1000, rx);
    spi_frame(16'h0000, 16, -1, 5, 12'hFFF, rx);
    check("t5_rx", {16'h0, rx}, 32'h0123);

    // 6: reset mid-frame
    frame(16'h2800, rx);
    check("t6_chnl5", {29'h0, chnl}, 32'd5);
    spi_frame(16'h3000, 16, 7, -1, 12'h0, rx);
    check("t6_cmd", {16'h0, cmd}, 32'h0);
    check("t6_chnl", {29'h0, chnl}, 32'd0);
    check("t6_no_pulse", done_seen * 100 + err_seen, exp_done * 100 + exp_err);
    frame(16'h0000, rx);
    check("t6_rx", {16'h0, rx}, 32'h0111);

    idle_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
